// File: rtl/i2s_to_wb_pkg.sv
// Shared register map, STATUS layout and default sizing for the Wishbone-fed I2S transmitter.
// Pure declarations; no latency or backpressure of its own.
package i2s_to_wb_pkg;

  localparam int SAMPLE_W_DEF   = 16;
  localparam int FIFO_DEPTH_DEF = 16;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DATA   = 2'd2;
  localparam logic [1:0] REG_UNMAP  = 2'd3;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_FLUSH = 1;

  localparam int ST_OVF     = 0;
  localparam int ST_UNF     = 1;
  localparam int ST_FULL    = 2;
  localparam int ST_EMPTY   = 3;
  localparam int ST_CNT_LSB = 8;

  function automatic logic [31:0] status_word(input logic [4:0] cnt, input logic empty,
                                              input logic full, input logic unf, input logic ovf);
    logic [31:0] s;
    s = '0;
    s[ST_CNT_LSB +: 5] = cnt;
    s[ST_EMPTY]        = empty;
    s[ST_FULL]         = full;
    s[ST_UNF]          = unf;
    s[ST_OVF]          = ovf;
    return s;
  endfunction

endpackage

// File: rtl/i2s_to_wb_fifo.sv
// Synchronous sample-word FIFO with occupancy count and flush; head word is visible combinationally.
// Push when full and pop when empty are ignored; flush wins over a same-cycle pop.
module i2s_to_wb_fifo #(
  parameter int DEPTH = 16,
  parameter int DAT_W = 32,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push_vld,
  input  logic [DAT_W-1:0] push_dat,
  input  logic             pop_rdy,
  output logic [DAT_W-1:0] pop_dat,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [DAT_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push_vld & ~full & ~flush;
  assign do_pop  = pop_rdy & ~empty & ~flush;
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/i2s_to_wb.sv
// Wishbone-fed I2S transmitter: register file, sample FIFO and bit serializer on one clock.
// Ack/err one cycle after request; sd follows a bit-clock fall within 3 cycles; full FIFO drops writes.
module i2s_to_wb
  import i2s_to_wb_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int SAMPLE_W   = SAMPLE_W_DEF
) (
  input  logic        i2s_clk_i,
  input  logic        i2s_rst_i,
  input  logic [31:0] wbs_data_i,
  output logic [31:0] wbs_data_o,
  input  logic [31:0] wbs_addr_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic        wbs_we_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  output logic        wbs_ack_o,
  output logic        wbs_err_o,
  output logic        wbs_rty_o,
  input  logic        i2s_sck_i,
  input  logic        i2s_ws_i,
  output logic        i2s_sd_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = $clog2(SAMPLE_W + 1);

  logic [1:0]    reg_sel;
  logic          wb_req, bad_acc, wr_ctrl, wr_data, flush;
  logic [31:0]   rd_val;
  logic          en, ovf, unf;
  logic [31:0]   fifo_dat;
  logic [CW-1:0] fifo_cnt;
  logic          fifo_full, fifo_empty, pop;
  logic          unused_bits;

  assign unused_bits = ^{wbs_sel_i, wbs_addr_i[31:4], wbs_addr_i[1:0]};
  assign wbs_rty_o   = 1'b0;

  assign reg_sel = wbs_addr_i[3:2];
  assign wb_req  = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o & ~wbs_err_o;
  assign bad_acc = (reg_sel == REG_UNMAP) | ((reg_sel == REG_STATUS) & wbs_we_i)
                 | ((reg_sel == REG_DATA) & ~wbs_we_i);
  assign wr_ctrl = wb_req & ~bad_acc & wbs_we_i & (reg_sel == REG_CTRL);
  assign wr_data = wb_req & ~bad_acc & wbs_we_i & (reg_sel == REG_DATA);
  assign flush   = wr_ctrl & wbs_data_i[CTRL_FLUSH];

  always_comb begin
    rd_val = '0;
    case (reg_sel)
      REG_CTRL:   rd_val = {31'b0, en};
      REG_STATUS: rd_val = status_word(5'(fifo_cnt), fifo_empty, fifo_full, unf, ovf);
      default:    rd_val = '0;
    endcase
  end

  always_ff @(posedge i2s_clk_i or negedge i2s_rst_i) begin
    if (!i2s_rst_i) begin
      wbs_ack_o  <= 1'b0;
      wbs_err_o  <= 1'b0;
      wbs_data_o <= '0;
      en         <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      wbs_ack_o  <= wb_req & ~bad_acc;
      wbs_err_o  <= wb_req & bad_acc;
      wbs_data_o <= (wb_req & ~bad_acc & ~wbs_we_i) ? rd_val : '0;
      if (wr_ctrl) en <= wbs_data_i[CTRL_EN];
      if (flush)                      ovf <= 1'b0;
      else if (wr_data && fifo_full)  ovf <= 1'b1;
    end
  end

  i2s_to_wb_fifo #(.DEPTH(FIFO_DEPTH), .DAT_W(32)) u_fifo (
    .clk      (i2s_clk_i),
    .rst_n    (i2s_rst_i),
    .flush    (flush),
    .push_vld (wr_data),
    .push_dat (wbs_data_i),
    .pop_rdy  (pop),
    .pop_dat  (fifo_dat),
    .count    (fifo_cnt),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // sck_sync[1] is the synchronized bit clock, sck_sync[2] its previous value for edge detect.
  logic [2:0]          sck_sync;
  logic [1:0]          ws_sync;
  logic                sck_rise, sck_fall, ws_cur, ws_prev, active;
  logic                left_start, right_start, underrun;
  logic [SAMPLE_W-1:0] shreg, right_hold, load_val;
  logic [BW-1:0]       bits_left;

  assign sck_rise    = sck_sync[1] & ~sck_sync[2];
  assign sck_fall    = ~sck_sync[1] & sck_sync[2];
  assign left_start  = sck_fall & ws_prev & ~ws_cur;
  assign right_start = sck_fall & ~ws_prev & ws_cur;
  assign pop         = left_start & en & ~fifo_empty;
  assign underrun    = left_start & en & fifo_empty;

  always_comb begin
    load_val = '0;
    if (left_start) load_val = pop ? fifo_dat[31 -: SAMPLE_W] : '0;
    else if (right_start && active) load_val = right_hold;
  end

  always_ff @(posedge i2s_clk_i or negedge i2s_rst_i) begin
    if (!i2s_rst_i) begin
      sck_sync   <= '0;
      ws_sync    <= '0;
      ws_cur     <= 1'b0;
      ws_prev    <= 1'b0;
      active     <= 1'b0;
      shreg      <= '0;
      right_hold <= '0;
      bits_left  <= '0;
      i2s_sd_o   <= 1'b0;
      unf        <= 1'b0;
    end else begin
      sck_sync <= {sck_sync[1:0], i2s_sck_i};
      ws_sync  <= {ws_sync[0], i2s_ws_i};
      if (sck_rise) begin
        ws_cur  <= ws_sync[1];
        ws_prev <= ws_cur;
      end
      if (left_start || right_start) begin
        i2s_sd_o  <= load_val[SAMPLE_W-1];
        shreg     <= {load_val[SAMPLE_W-2:0], 1'b0};
        bits_left <= BW'(SAMPLE_W - 1);
      end else if (sck_fall) begin
        if (bits_left != '0) begin
          i2s_sd_o  <= shreg[SAMPLE_W-1];
          shreg     <= {shreg[SAMPLE_W-2:0], 1'b0};
          bits_left <= bits_left - 1'b1;
        end else begin
          i2s_sd_o  <= 1'b0;
        end
      end
      // Frames only start at a left slot, so a reset mid-frame stays silent until the next ws fall.
      if (left_start) begin
        active     <= 1'b1;
        right_hold <= pop ? fifo_dat[15 -: SAMPLE_W] : '0;
      end
      if (flush)         unf <= 1'b0;
      else if (underrun) unf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_i2s_to_wb.sv
// Directed bench: Wishbone register traffic plus a free-running I2S bit clock (clk/8, 32 sck per slot).
// Received frames are assembled as {left, pad, right, pad} and compared against hand-computed words.
module tb_i2s_to_wb;

  logic        tb_clk = 1'b0;
  logic        i2s_rst_i;
  logic [31:0] wbs_data_i, wbs_data_o, wbs_addr_i;
  logic [3:0]  wbs_sel_i;
  logic        wbs_we_i, wbs_cyc_i, wbs_stb_i;
  logic        wbs_ack_o, wbs_err_o, wbs_rty_o;
  logic        i2s_sck_i, i2s_ws_i, i2s_sd_o;

  int          n_cmp = 0;
  int          n_mis = 0;
  int          pos, div, frame_cnt, ones;
  logic [63:0] rx_sh, rx_frame;

  always #5 tb_clk = ~tb_clk;

  i2s_to_wb dut (
    .i2s_clk_i  (tb_clk),
    .i2s_rst_i  (i2s_rst_i),
    .wbs_data_i (wbs_data_i),
    .wbs_data_o (wbs_data_o),
    .wbs_addr_i (wbs_addr_i),
    .wbs_sel_i  (wbs_sel_i),
    .wbs_we_i   (wbs_we_i),
    .wbs_cyc_i  (wbs_cyc_i),
    .wbs_stb_i  (wbs_stb_i),
    .wbs_ack_o  (wbs_ack_o),
    .wbs_err_o  (wbs_err_o),
    .wbs_rty_o  (wbs_rty_o),
    .i2s_sck_i  (i2s_sck_i),
    .i2s_ws_i   (i2s_ws_i),
    .i2s_sd_o   (i2s_sd_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // I2S master: ws changes on sck fall, receiver samples sd on sck rise.
  initial begin
    i2s_sck_i = 1'b1;
    i2s_ws_i  = 1'b1;
    pos = 63; div = 0; frame_cnt = 0; ones = 0;
    rx_sh = '0; rx_frame = '0;
    forever begin
      @(negedge tb_clk);
      div++;
      if (div == 4) begin
        div = 0;
        if (i2s_sck_i) begin
          i2s_sck_i = 1'b0;
          pos = (pos + 1) % 64;
          i2s_ws_i = (pos >= 32);
        end else begin
          i2s_sck_i = 1'b1;
          rx_sh = {rx_sh[62:0], i2s_sd_o};
          if (i2s_sd_o) ones++;
          if (pos == 0) begin
            rx_frame = rx_sh;
            frame_cnt++;
          end
        end
      end
    end
  end

  task automatic wb_xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdat,
                         output logic [31:0] rdat, output logic [3:0] hs);
    logic got_ack, got_err, one_cyc;
    int   lat;
    @(negedge tb_clk);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_addr_i = addr; wbs_data_i = wdat; wbs_sel_i = 4'hF;
    got_ack = 1'b0; got_err = 1'b0; rdat = '0; lat = 0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge tb_clk); #1;
      if (wbs_ack_o || wbs_err_o) begin
        got_ack = wbs_ack_o; got_err = wbs_err_o; rdat = wbs_data_o; lat = i;
        break;
      end
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    @(posedge tb_clk); #1;
    one_cyc = !wbs_ack_o && !wbs_err_o && (wbs_data_o == 32'h0);
    hs = {got_ack, got_err, (lat == 1), one_cyc};
  endtask

  task automatic wb_write(input string tag, input logic [31:0] addr, input logic [31:0] wdat);
    logic [31:0] rd;
    logic [3:0]  hs;
    wb_xfer(1'b1, addr, wdat, rd, hs);
    check({tag, "_ack"}, hs, 4'b1011);
  endtask

  task automatic wb_read(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] rd;
    logic [3:0]  hs;
    wb_xfer(1'b0, addr, 32'h0, rd, hs);
    check({tag, "_ack"}, hs, 4'b1011);
    check(tag, rd, exp);
  endtask

  task automatic wb_bad(input string tag, input logic we, input logic [31:0] addr);
    logic [31:0] rd;
    logic [3:0]  hs;
    wb_xfer(we, addr, 32'hFFFF_FFFF, rd, hs);
    check({tag, "_err"}, hs, 4'b0111);
    check({tag, "_dat"}, rd, 32'h0);
  endtask

  task automatic wait_frame();
    int c0;
    bit seen;
    c0 = frame_cnt; seen = 0;
    for (int i = 0; i < 1200; i++) begin
      @(negedge tb_clk);
      if (frame_cnt != c0) begin seen = 1; break; end
    end
    if (!seen) check("frame_timeout", 0, 1);
  endtask

  task automatic wait_pos(input int p);
    bit seen;
    seen = 0;
    for (int i = 0; i < 1200; i++) begin
      @(negedge tb_clk);
      if (pos == p) begin seen = 1; break; end
    end
    if (!seen) check("pos_timeout", 0, 1);
  endtask

  initial begin
    i2s_rst_i = 1'b0;
    wbs_data_i = '0; wbs_addr_i = '0; wbs_sel_i = '0;
    wbs_we_i = 1'b0; wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    repeat (4) @(negedge tb_clk);
    check("rst_outs_in", {i2s_sd_o, wbs_ack_o, wbs_err_o, wbs_rty_o, wbs_data_o}, 64'h0);
    i2s_rst_i = 1'b1;
    @(negedge tb_clk);
    check("rst_outs", {i2s_sd_o, wbs_ack_o, wbs_err_o, wbs_rty_o, wbs_data_o}, 64'h0);
    wb_read("rst_status", 32'h4, 32'h0000_0008);
    wb_read("rst_ctrl", 32'h0, 32'h0);

    wb_bad("err_rd_unmap", 1'b0, 32'hC);
    wb_bad("err_wr_status", 1'b1, 32'h4);
    wb_bad("err_rd_data", 1'b0, 32'h8);
    wb_read("err_status_kept", 32'h4, 32'h0000_0008);
    wb_read("err_ctrl_kept", 32'h0, 32'h0);

    // 17 writes into a 16-deep FIFO with EN=0: last one is acked and dropped.
    for (int i = 0; i < 17; i++) wb_write("fill", 32'h8, 32'h1000_0000 + i);
    wb_read("full_status", 32'h4, 32'h0000_1005);
    wait_frame();
    wait_frame();
    check("en0_frame", rx_frame, 64'h0);
    wb_read("en0_no_pop", 32'h4, 32'h0000_1005);
    wb_write("flush", 32'h0, 32'h2);
    wb_read("flush_status", 32'h4, 32'h0000_0008);
    wb_read("flush_selfclr", 32'h0, 32'h0);

    wait_pos(16);
    wb_write("d0", 32'h8, 32'hA5A5_3C3C);
    wb_write("d1", 32'h8, 32'h1234_5678);
    wb_write("d2", 32'h8, 32'h8001_FFFE);
    wb_read("cnt3_status", 32'h4, 32'h0000_0300);
    wb_write("en", 32'h0, 32'h1);
    wb_read("en_ctrl", 32'h0, 32'h1);
    wait_frame();
    wait_frame();
    check("frame_a5a5", rx_frame, 64'hA5A5_0000_3C3C_0000);
    wait_frame();
    check("frame_1234", rx_frame, 64'h1234_0000_5678_0000);
    wait_frame();
    check("frame_8001", rx_frame, 64'h8001_0000_FFFE_0000);
    wait_pos(16);
    wb_read("unf_status", 32'h4, 32'h0000_000A);
    wait_frame();
    check("unf_frame", rx_frame, 64'h0);
    wb_write("clr", 32'h0, 32'h3);
    wb_read("clr_status", 32'h4, 32'h0000_0008);

    wait_pos(16);
    wb_write("dff", 32'h8, 32'hFFFF_FFFF);
    wait_frame();
    wait_pos(8);
    check("mid_sd", i2s_sd_o, 1);
    i2s_rst_i = 1'b0;
    ones = 0;
    #1;
    check("rst_sd_now", i2s_sd_o, 0);
    repeat (3) @(negedge tb_clk);
    check("rst_mid_outs", {i2s_sd_o, wbs_ack_o, wbs_err_o, wbs_rty_o, wbs_data_o}, 64'h0);
    i2s_rst_i = 1'b1;
    wb_write("post_d", 32'h8, 32'hFFFF_FFFF);
    wb_write("post_en", 32'h0, 32'h1);
    wb_read("post_status", 32'h4, 32'h0000_0100);
    wait_frame();
    check("post_quiet", ones, 0);
    wait_frame();
    check("post_frame", rx_frame, 64'hFFFF_0000_FFFF_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
